// File: rtl/sfp_ctrl_pkg.sv
// Shared definitions for the SFP sequencer: FSM encoding, command modes, OFIFO usage decode.
// No logic of its own; imported by sfp_ctrl and sfp_addr_gen.
package sfp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_PASS     = 2'b00;
  localparam logic [1:0] MODE_ACC      = 2'b01;
  localparam logic [1:0] MODE_ACC_RELU = 2'b10;
  localparam logic [1:0] MODE_RELU     = 2'b11;

  // ReLU-in-place works on PSUM contents alone; every other mode consumes one OFIFO entry per row.
  function automatic logic needs_ofifo(input logic [1:0] mode);
    return mode != MODE_RELU;
  endfunction

endpackage

// File: rtl/sfp_addr_gen.sv
// Row counter and PSUM address generator: addr = base + row (wraps), last flag when row+1 == count.
// Zero latency on the address; counter clears on an accepted command and advances once per WR cycle.
module sfp_addr_gen #(
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clr,
  input  logic               i_adv,
  input  logic [addr_bw-1:0] i_base,
  input  logic [cnt_bw-1:0]  i_count,
  output logic [addr_bw-1:0] o_addr,
  output logic               o_last
);

  logic [cnt_bw-1:0] r_row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= '0;
    end else if (i_clr) begin
      r_row <= '0;
    end else if (i_adv) begin
      r_row <= r_row + cnt_bw'(1);
    end
  end

  assign o_addr = i_base + addr_bw'(r_row);
  assign o_last = (r_row + cnt_bw'(1)) == i_count;

endmodule

// File: rtl/sfp_ctrl.sv
// SFP sequencer: per row RD (with OFIFO pop) then WR of the same PSUM row; done pulse after last row.
// Two cycles per row; RD stalls while a needed OFIFO entry is absent; start is ignored while busy.
module sfp_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [cnt_bw-1:0]  count,
  output logic               busy,
  output logic               done,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [addr_bw-1:0] sram_addr,
  output logic               sfp_passthrough,
  output logic               sfp_accum,
  output logic               sfp_relu
);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_mode;
  logic [addr_bw-1:0] r_base;
  logic [cnt_bw-1:0]  r_count;
  logic               w_accept;
  logic               w_need;
  logic               w_stall;
  logic [addr_bw-1:0] w_addr;
  logic               w_last;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_need   = needs_ofifo(r_mode);
  assign w_stall  = w_need && !ofifo_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_mode  <= '0;
      r_base  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode  <= mode;
        r_base  <= base_addr;
        r_count <= count;
      end
    end
  end

  sfp_addr_gen #(
    .addr_bw (addr_bw),
    .cnt_bw  (cnt_bw)
  ) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_accept),
    .i_adv   (r_state == ST_WR),
    .i_base  (r_base),
    .i_count (r_count),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  always_comb begin
    w_next          = r_state;
    busy            = 1'b0;
    done            = 1'b0;
    ofifo_rd        = 1'b0;
    sram_cen        = 1'b1;
    sram_wen        = 1'b1;
    sram_addr       = '0;
    sfp_passthrough = 1'b0;
    sfp_accum       = 1'b0;
    sfp_relu        = 1'b0;

    if (r_state != ST_IDLE) begin
      sfp_passthrough = (r_mode == MODE_PASS);
      sfp_accum       = (r_mode == MODE_ACC) || (r_mode == MODE_ACC_RELU);
      sfp_relu        = (r_mode == MODE_ACC_RELU) || (r_mode == MODE_RELU);
    end

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (count == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        busy = 1'b1;
        if (!w_stall) begin
          sram_cen  = 1'b0;
          sram_addr = w_addr;
          ofifo_rd  = w_need;
          w_next    = ST_WR;
        end
      end
      ST_WR: begin
        busy      = 1'b1;
        sram_cen  = 1'b0;
        sram_wen  = 1'b0;
        sram_addr = w_addr;
        w_next    = w_last ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sfp_ctrl.sv
// Scoreboard bench for sfp_ctrl: stimulus pushes expected per-cycle bus events, a negedge monitor
// pops and compares them, with a behavioural PSUM SRAM, OFIFO and SFP datapath around the DUT.
module tb_sfp_ctrl;
  import sfp_ctrl_pkg::*;

  localparam int AW = 11;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
  logic          ofifo_valid = 1'b1;
  logic          busy, done, ofifo_rd, sram_cen, sram_wen;
  logic [AW-1:0] sram_addr;
  logic          sfp_passthrough, sfp_accum, sfp_relu;

  sfp_ctrl #(.addr_bw(AW), .cnt_bw(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .mode            (mode),
    .base_addr       (base_addr),
    .count           (count),
    .busy            (busy),
    .done            (done),
    .ofifo_valid     (ofifo_valid),
    .ofifo_rd        (ofifo_rd),
    .sram_cen        (sram_cen),
    .sram_wen        (sram_wen),
    .sram_addr       (sram_addr),
    .sfp_passthrough (sfp_passthrough),
    .sfp_accum       (sfp_accum),
    .sfp_relu        (sfp_relu)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [18:0] vec;
    int          data;
  } ev_t;

  ev_t expq[$];
  int  ofq[$];
  int  mem[2048];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  stall_lo = 0;
  int  stall_hi = 0;
  int  last_of = 0;
  int  rd_q = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    ofifo_valid = !(cyc >= stall_lo && cyc < stall_hi);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] ctl(input logic [1:0] m);
    return {m == MODE_PASS, (m == MODE_ACC) || (m == MODE_ACC_RELU),
            (m == MODE_ACC_RELU) || (m == MODE_RELU)};
  endfunction

  task automatic exp_ev(input int c, input logic cen, input logic wen, input logic [AW-1:0] a,
                        input logic pop, input logic dn, input logic [1:0] m, input int data);
    ev_t e;
    e.cyc  = c;
    e.vec  = {cen, wen, a, pop, dn, 1'b1, ctl(m)};
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic exp_row(input int c, input logic [AW-1:0] a, input logic pop,
                         input logic [1:0] m, input int data);
    exp_ev(c, 1'b0, 1'b1, a, pop, 1'b0, m, 0);
    exp_ev(c + 1, 1'b0, 1'b0, a, 1'b0, 1'b0, m, data);
  endtask

  task automatic exp_done(input int c, input logic [1:0] m);
    exp_ev(c, 1'b1, 1'b1, '0, 1'b0, 1'b1, m, 0);
  endtask

  // Monitor: any cycle with SRAM access, OFIFO pop or done must match the next expected event.
  always @(negedge clk) begin
    logic [18:0] v;
    ev_t         e;
    int          in_v;
    int          d;
    if (!sram_cen || ofifo_rd || done) begin
      v = {sram_cen, sram_wen, sram_addr, ofifo_rd, done, busy,
           sfp_passthrough, sfp_accum, sfp_relu};
      if (!sram_cen && !sram_wen) begin
        if (sfp_accum) in_v = rd_q + last_of;
        else if (sfp_passthrough) in_v = last_of;
        else in_v = rd_q;
        d = (sfp_relu && in_v < 0) ? 0 : in_v;
        mem[sram_addr] = d;
      end else begin
        d = 0;
      end
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event @cycle %0d: got %h, expected no activity", cyc, v);
      end else begin
        e = expq.pop_front();
        check("event", {13'd0, 32'(cyc), v}, {13'd0, 32'(e.cyc), e.vec});
        if (!sram_cen && !sram_wen) check("wdata", 64'(d), 64'(e.data));
      end
      if (!sram_cen && sram_wen) rd_q = mem[sram_addr];
      if (ofifo_rd) last_of = (ofq.size() != 0) ? ofq.pop_front() : 0;
    end
  end

  task automatic check_reset(input string name);
    check(name, {45'd0, busy, done, ofifo_rd, sram_cen, sram_wen, sram_addr,
                 sfp_passthrough, sfp_accum, sfp_relu},
          {45'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 3'b000});
  endtask

  task automatic issue(input logic [1:0] m, input logic [AW-1:0] b, input logic [CW-1:0] n,
                       output int t);
    @(negedge clk);
    #1;
    mode = m;
    base_addr = b;
    count = n;
    start = 1'b1;
    t = cyc;
  endtask

  task automatic end_start();
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (expq.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d events pending after %0d cycles, expected 0",
               name, expq.size(), budget);
      expq.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset("idle_after_reset");

    // Accumulate, 3 rows from 4; a second start mid-command must be ignored.
    mem[4] = 5; mem[5] = 10; mem[6] = -3;
    ofq = '{-2, 7, 1};
    issue(MODE_ACC, 11'd4, 11'd3, t);
    exp_row(t + 1, 11'd4, 1'b1, MODE_ACC, 3);
    exp_row(t + 3, 11'd5, 1'b1, MODE_ACC, 17);
    exp_row(t + 5, 11'd6, 1'b1, MODE_ACC, -2);
    exp_done(t + 7, MODE_ACC);
    end_start();
    @(negedge clk);
    #1;
    mode = MODE_RELU; base_addr = 11'd0; count = 11'd5; start = 1'b1;
    end_start();
    drain("acc", 40);

    // Accumulate+ReLU with OFIFO empty for three cycles before row 1.
    mem[100] = 1; mem[101] = 3;
    ofq = '{-4, 4};
    issue(MODE_ACC_RELU, 11'd100, 11'd2, t);
    stall_lo = t + 3;
    stall_hi = t + 6;
    exp_row(t + 1, 11'd100, 1'b1, MODE_ACC_RELU, 0);
    exp_row(t + 6, 11'd101, 1'b1, MODE_ACC_RELU, 7);
    exp_done(t + 8, MODE_ACC_RELU);
    end_start();
    drain("acc_relu_stall", 40);

    // ReLU in place runs with the OFIFO permanently empty and never pops.
    mem[200] = -6; mem[201] = 8;
    stall_lo = 0;
    stall_hi = 1 << 30;
    issue(MODE_RELU, 11'd200, 11'd2, t);
    exp_row(t + 1, 11'd200, 1'b0, MODE_RELU, 0);
    exp_row(t + 3, 11'd201, 1'b0, MODE_RELU, 8);
    exp_done(t + 5, MODE_RELU);
    end_start();
    drain("relu", 40);
    stall_hi = 0;

    issue(MODE_PASS, 11'd7, 11'd0, t);
    exp_done(t + 1, MODE_PASS);
    end_start();
    drain("count_zero", 20);

    // Passthrough across the top of the address space.
    ofq = '{11, -12};
    issue(MODE_PASS, 11'd2047, 11'd2, t);
    exp_row(t + 1, 11'd2047, 1'b1, MODE_PASS, 11);
    exp_row(t + 3, 11'd0, 1'b1, MODE_PASS, -12);
    exp_done(t + 5, MODE_PASS);
    end_start();
    drain("wrap", 40);

    // Reset during the first WR: outputs drop at once and no done follows.
    mem[300] = 2;
    ofq = '{1};
    issue(MODE_ACC, 11'd300, 11'd3, t);
    exp_ev(t + 1, 1'b0, 1'b1, 11'd300, 1'b1, 1'b0, MODE_ACC, 0);
    end_start();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset("reset_in_wr");
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    drain("after_reset", 10);
    repeat (6) @(negedge clk);
    check_reset("idle_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
